// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: buffers register-writing retirements from the core's
// write-back stage and presents them on a valid/ready trace port.
// The core is never stalled. A capture that arrives while the FIFO is full,
// with no pop in the same cycle, is dropped and counted.
// Optional build macro WB_TRACE_SKIP_R0_EN: when defined, writes to $0 are
// ignored. They are neither stored nor counted as drops.
module wb_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trace_en,
    input  logic              trace_clr,
    input  logic [31:0]       debug_wb_pc,
    input  logic [3:0]        debug_wb_rf_wen,
    input  logic [4:0]        debug_wb_rf_wnum,
    input  logic [31:0]       debug_wb_rf_wdata,
    output logic              trace_valid,
    input  logic              trace_ready,
    output logic [31:0]       trace_pc,
    output logic [3:0]        trace_wen,
    output logic [4:0]        trace_wnum,
    output logic [31:0]       trace_wdata,
    output logic [ADDR_W:0]   trace_count,
    output logic              trace_overflow,
    output logic [15:0]       trace_drop_cnt
);

    localparam int ENTRY_W = 73;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  head;
    logic [ADDR_W-1:0]  tail;
    logic [ADDR_W:0]    count;
    logic               overflow;
    logic [15:0]        drop_cnt;

    logic               push_req;
    logic               pop;
    logic               full;
    logic               do_push;
    logic               drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Capture qualification: only retirements that actually write the register file.
    always_comb begin
        push_req = trace_en && (debug_wb_rf_wen != 4'b0000);
`ifdef WB_TRACE_SKIP_R0_EN
        push_req = push_req && (debug_wb_rf_wnum != 5'd0);
`endif
    end

    assign trace_valid = (count != '0);
    assign full        = (count == FULL_COUNT);
    assign pop         = trace_valid && trace_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push     = push_req && (!full || pop);
    assign drop        = push_req && full && !pop;
    assign wr_entry    = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
    assign head_entry  = mem[head];

    // Storage write. The contents are not reset. Validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[tail] <= wr_entry;
        end
    end

    // Head/tail pointers wrap naturally at DEPTH because it is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
        end
    end

    // Occupancy tracking. A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Overflow flag and saturating drop counter. A clear wins over a same-cycle drop,
    // but that drop is still counted as the first drop after the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (trace_clr) begin
            overflow <= 1'b0;
            drop_cnt <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Head entry is shown only while valid. An empty FIFO shows all zeros.
    always_comb begin
        {trace_pc, trace_wen, trace_wnum, trace_wdata} = '0;
        if (trace_valid) begin
            {trace_pc, trace_wen, trace_wnum, trace_wdata} = head_entry;
        end
    end

    assign trace_count    = count;
    assign trace_overflow = overflow;
    assign trace_drop_cnt = drop_cnt;

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Sits directly downstream of the CPU core's write-back stage.
- Consumes the retire/debug write-back stream (pc, rf write enable, rf write number, rf write data) and buffers register-writing retirements in a FIFO.
- Presents buffered entries on a valid/ready trace port for a trace sink or host-side checker.
- Runs in the core clock domain. It does not backpressure the core: when the FIFO is full, entries are dropped and counted.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, 4..256.
- ADDR_W, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- trace_en  input  1  capture enable; 0 = ignore write-back stream.
- trace_clr  input  1  synchronous clear of overflow flag and drop counter (FIFO contents untouched).
- debug_wb_pc  input  32  PC of retiring instruction.
- debug_wb_rf_wen  input  4  rf byte write enables from write-back.
- debug_wb_rf_wnum  input  5  destination register number.
- debug_wb_rf_wdata  input  32  write data.
- trace_valid  output  1  head entry available.
- trace_ready  input  1  sink accepts head entry.
- trace_pc  output  32  head entry PC.
- trace_wen  output  4  head entry byte enables.
- trace_wnum  output  5  head entry register number.
- trace_wdata  output  32  head entry data.
- trace_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- trace_overflow  output  1  sticky: at least one capture dropped.
- trace_drop_cnt  output  16  number of dropped captures, saturating.

Behaviour:
- Entry format: 73 bits {pc, wen, wnum, wdata}, stored in a DEPTH-entry array with head/tail pointers of ADDR_W bits wrapping modulo DEPTH.
- push_req = trace_en and (debug_wb_rf_wen != 4'b0000), evaluated every cycle.
- pop = trace_valid and trace_ready.
- trace_valid = (count != 0).
- Trace data outputs reflect mem[head] combinationally while trace_valid = 1, and are forced to all zeros when count = 0.
- Latency: an entry pushed at edge N is visible with trace_valid = 1 after edge N (no bypass when empty). An empty FIFO never presents the same-cycle input.
- Push only (not full): write mem[tail], tail+1, count+1.
- Pop only: head+1, count-1.
- Push and pop in the same cycle, including when full: both occur and count is unchanged, so no drop.
- Push and pop when empty: pop is impossible (trace_valid = 0), so push proceeds.
- Push when full with no pop: entry discarded, trace_overflow <= 1, trace_drop_cnt <= trace_drop_cnt+1, saturating at 16'hFFFF.
- Pointers wrap from DEPTH-1 to 0 with no bubble.
- count is held as ADDR_W+1 bits so full (count = DEPTH) is distinguishable from empty.
- trace_clr = 1: trace_overflow <= 0 and trace_drop_cnt <= 0. If a drop occurs in the same cycle, clear wins on overflow, and drop_cnt <= 1.
- trace_en deasserted mid-stream: stops new captures only; already buffered entries continue to drain.
- Reset (rst = 0 at edge), also when asserted mid-operation:
  - head = tail = count = 0.
  - trace_overflow = 0, trace_drop_cnt = 0.
  - trace_valid = 0, and all trace data outputs = 0.
  - Memory contents need not be cleared.
  - Inputs are ignored during reset, including push, pop and clr.
- trace_ready is ignored while trace_valid = 0.

Optional Feature:
- Macro: WB_TRACE_SKIP_R0_EN.
- Defined: push_req additionally requires debug_wb_rf_wnum != 5'd0. Writes to $0 are neither stored nor counted as drops.
- Undefined: $0 writes with nonzero wen are captured like any other register.

Test Plan:
- Reset, then a single write-back (pc 32'hBFC00000, wen 4'hF, wnum 5'd8, wdata 32'h00000011) -> trace_valid rises the next cycle with matching fields. trace_ready = 1 for one cycle -> trace_valid = 0 and trace outputs = 0.
- trace_ready held 0, then 20 consecutive captures with DEPTH = 16 -> trace_count = 16, trace_overflow = 1, trace_drop_cnt = 4. Draining yields the first 16 entries in order. trace_clr then gives overflow = 0, drop_cnt = 0.
- FIFO full with trace_ready = 1 and a capture in the same cycle -> no drop, count stays 16. Run 40 entries at continuous push/pop -> pointers wrap and output order is preserved.
- Write-back with wen = 0, or with trace_en = 0 -> count is unchanged. With WB_TRACE_SKIP_R0_EN defined, a wnum = 0, wen = 4'hF capture -> not stored; without the macro -> stored.
- rst driven low for one cycle while count = 5 and overflow = 1 -> next cycle count = 0, trace_valid = 0, overflow = 0, drop_cnt = 0. A capture in the first post-reset cycle is accepted normally.
- Force drop_cnt to 16'hFFFE, then cause 3 drops -> saturates at 16'hFFFF. Assert trace_clr together with a drop -> overflow = 0, drop_cnt = 1.
